// File: rtl/relay_buzz_seq.sv
// Multi-channel relay/buzzer sequencer: each channel emits a programmable square wave,
// either continuously or as a burst of N full periods that ends with a done pulse.
module relay_buzz_seq #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 26,
    parameter int BURST_W = 8
) (
    input  logic                   osc,
    input  logic                   reset_n,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         stop,
    input  logic [NCH-1:0]         mode,
    input  logic [NCH*CNT_W-1:0]   half_period,
    input  logic [NCH*BURST_W-1:0] burst_len,
    output logic [NCH-1:0]         out,
    output logic [NCH-1:0]         busy,
    output logic [NCH-1:0]         done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t             state, state_nxt;
        logic [CNT_W-1:0]   cnt, cnt_nxt;
        logic [CNT_W-1:0]   hp, hp_nxt;
        logic [BURST_W-1:0] blen, blen_nxt;
        logic [BURST_W:0]   edge_cnt, edge_nxt;
        logic               burst, burst_nxt;
        logic               out_r, out_nxt;
        logic               done_r, done_nxt;

        logic [CNT_W-1:0]   hp_last;
        logic [BURST_W:0]   edge_inc;
        logic [BURST_W:0]   burst_edges;

        // A latched half-period of zero behaves like one: toggle on every cycle.
        assign hp_last     = (hp == '0) ? '0 : hp - CNT_W'(1);
        assign edge_inc    = edge_cnt + (BURST_W + 1)'(1);
        assign burst_edges = {blen, 1'b0};

        always_ff @(posedge osc or negedge reset_n) begin
            if (!reset_n) begin
                state    <= IDLE;
                cnt      <= '0;
                hp       <= '0;
                blen     <= '0;
                edge_cnt <= '0;
                burst    <= 1'b0;
                out_r    <= 1'b0;
                done_r   <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                hp       <= hp_nxt;
                blen     <= blen_nxt;
                edge_cnt <= edge_nxt;
                burst    <= burst_nxt;
                out_r    <= out_nxt;
                done_r   <= done_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            hp_nxt    = hp;
            blen_nxt  = blen;
            edge_nxt  = edge_cnt;
            burst_nxt = burst;
            out_nxt   = out_r;
            done_nxt  = 1'b0;

            case (state)
                IDLE: begin
                    out_nxt = 1'b0;
                    if (start[i] && !stop[i]) begin
                        state_nxt = RUN;
                        burst_nxt = mode[i];
                        hp_nxt    = half_period[i*CNT_W +: CNT_W];
                        blen_nxt  = burst_len[i*BURST_W +: BURST_W];
                        cnt_nxt   = '0;
                        edge_nxt  = '0;
                    end
                end
                RUN: begin
                    if (stop[i]) begin
                        state_nxt = IDLE;
                        out_nxt   = 1'b0;
                    end else if (burst && blen == '0) begin
                        state_nxt = IDLE;
                        out_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (cnt == hp_last) begin
                        cnt_nxt  = '0;
                        edge_nxt = edge_inc;
                        out_nxt  = ~out_r;
                        // The final falling toggle of a burst also retires the channel.
                        if (burst && edge_inc == burst_edges) begin
                            state_nxt = IDLE;
                            out_nxt   = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    out_nxt   = 1'b0;
                end
            endcase
        end

        assign out[i]  = out_r;
        assign busy[i] = (state == RUN);
        assign done[i] = done_r;
    end

endmodule

// File: tb/tb_relay_buzz_seq.sv
// Directed self-checking bench for relay_buzz_seq; expected waveforms are derived
// from the half-period/burst arithmetic relative to the start edge k.
module tb_relay_buzz_seq;

    localparam int NCH     = 2;
    localparam int CNT_W   = 26;
    localparam int BURST_W = 8;

    logic                   osc;
    logic                   reset_n;
    logic [NCH-1:0]         start;
    logic [NCH-1:0]         stop;
    logic [NCH-1:0]         mode;
    logic [NCH*CNT_W-1:0]   half_period;
    logic [NCH*BURST_W-1:0] burst_len;
    logic [NCH-1:0]         out;
    logic [NCH-1:0]         busy;
    logic [NCH-1:0]         done;

    int n_cmp  = 0;
    int n_fail = 0;

    relay_buzz_seq #(
        .NCH    (NCH),
        .CNT_W  (CNT_W),
        .BURST_W(BURST_W)
    ) dut (
        .osc        (osc),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .half_period(half_period),
        .burst_len  (burst_len),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge osc);
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        start       = '1;
        stop        = '0;
        mode        = '0;
        half_period = '0;
        burst_len   = '0;
        repeat (3) tick();
        n_cmp++;
        if (out !== '0 || busy !== '0 || done !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: out=%b busy=%b done=%b required 00/00/00", out, busy, done);
        end
        start   = '0;
        reset_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (out !== '0 || busy !== '0 || done !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: out=%b busy=%b done=%b required 00/00/00", out, busy, done);
        end
    endtask

    task automatic test_continuous();
        mode[0]                 = 1'b0;
        half_period[0 +: CNT_W] = CNT_W'(4);
        start[0]                = 1'b1;
        tick();
        start[0] = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b1 || out[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cont_start: busy=%b out=%b required 1/0", busy[0], out[0]);
        end
        for (int j = 1; j <= 24; j++) begin
            logic exp_o;
            tick();
            exp_o = ((j / 4) % 2) == 1;
            n_cmp++;
            if (out[0] !== exp_o || done[0] !== 1'b0 || busy[0] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL cont_wave k+%0d: out=%b done=%b busy=%b required %b/0/1",
                         j, out[0], done[0], busy[0], exp_o);
            end
        end
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        n_cmp++;
        if (out[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cont_stop: out=%b busy=%b done=%b required 0/0/0", out[0], busy[0], done[0]);
        end
    endtask

    task automatic test_burst();
        mode[1]                        = 1'b1;
        half_period[CNT_W +: CNT_W]    = CNT_W'(3);
        burst_len[BURST_W +: BURST_W]  = BURST_W'(2);
        start[1]                       = 1'b1;
        tick();
        start[1] = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            logic exp_o, exp_d, exp_b;
            // Start arriving in the same cycle done is produced must be ignored.
            if (j == 12) start[1] = 1'b1;
            tick();
            start[1] = 1'b0;
            exp_o = (j >= 3 && j < 6) || (j >= 9 && j < 12);
            exp_d = (j == 12);
            exp_b = (j < 12);
            n_cmp++;
            if (out[1] !== exp_o || done[1] !== exp_d || busy[1] !== exp_b) begin
                n_fail++;
                $display("[TB] FAIL burst k+%0d: out=%b done=%b busy=%b required %b/%b/%b",
                         j, out[1], done[1], busy[1], exp_o, exp_d, exp_b);
            end
        end
        for (int j = 13; j <= 16; j++) begin
            tick();
            n_cmp++;
            if (out[1] !== 1'b0 || done[1] !== 1'b0 || busy[1] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL burst_after k+%0d: out=%b done=%b busy=%b required 0/0/0",
                         j, out[1], done[1], busy[1]);
            end
        end
    endtask

    task automatic test_edge_cases();
        // Zero half-period toggles every cycle.
        mode[0]                 = 1'b0;
        half_period[0 +: CNT_W] = '0;
        start[0]                = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            logic exp_o;
            tick();
            exp_o = (j % 2) == 1;
            n_cmp++;
            if (out[0] !== exp_o) begin
                n_fail++;
                $display("[TB] FAIL hp0 k+%0d: out=%b required %b", j, out[0], exp_o);
            end
        end
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;

        // Zero-length burst finishes one edge after starting.
        mode[1]                       = 1'b1;
        half_period[CNT_W +: CNT_W]   = CNT_W'(3);
        burst_len[BURST_W +: BURST_W] = '0;
        start[1]                      = 1'b1;
        tick();
        start[1] = 1'b0;
        n_cmp++;
        if (busy[1] !== 1'b1 || done[1] !== 1'b0 || out[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL len0_k: busy=%b done=%b out=%b required 1/0/0", busy[1], done[1], out[1]);
        end
        tick();
        n_cmp++;
        if (busy[1] !== 1'b0 || done[1] !== 1'b1 || out[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL len0_k1: busy=%b done=%b out=%b required 0/1/0", busy[1], done[1], out[1]);
        end
        tick();
        n_cmp++;
        if (done[1] !== 1'b0 || out[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL len0_k2: done=%b out=%b required 0/0", done[1], out[1]);
        end

        // Start and stop together: stop wins in RUN, nothing happens in IDLE.
        half_period[0 +: CNT_W] = CNT_W'(4);
        start[0]                = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        start[0] = 1'b1;
        stop[0]  = 1'b1;
        tick();
        n_cmp++;
        if (busy[0] !== 1'b0 || out[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL startstop_run: busy=%b out=%b required 0/0", busy[0], out[0]);
        end
        tick();
        start[0] = 1'b0;
        stop[0]  = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL startstop_idle: busy=%b required 0", busy[0]);
        end

        // Restart attempt with a different half-period while running is ignored.
        half_period[0 +: CNT_W] = CNT_W'(4);
        start[0]                = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            logic exp_o;
            if (j == 2) begin
                half_period[0 +: CNT_W] = CNT_W'(2);
                start[0]                = 1'b1;
            end
            tick();
            start[0] = 1'b0;
            exp_o = ((j / 4) % 2) == 1;
            n_cmp++;
            if (out[0] !== exp_o || busy[0] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL restart_ignored k+%0d: out=%b busy=%b required %b/1", j, out[0], busy[0], exp_o);
            end
        end
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
    endtask

    task automatic test_independence();
        mode                          = 2'b10;
        half_period[0 +: CNT_W]       = CNT_W'(5);
        half_period[CNT_W +: CNT_W]   = CNT_W'(2);
        burst_len[BURST_W +: BURST_W] = BURST_W'(3);
        start[0]                      = 1'b1;
        tick();
        start[0] = 1'b0;
        start[1] = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            int   m;
            logic exp_o0, exp_o1, exp_d1, exp_b1;
            tick();
            start[1] = 1'b0;
            m      = j - 1;
            exp_o0 = ((j / 5) % 2) == 1;
            exp_o1 = (m >= 2 && m < 4) || (m >= 6 && m < 8) || (m >= 10 && m < 12);
            exp_d1 = (m == 12);
            exp_b1 = (m < 12);
            n_cmp++;
            if (out[0] !== exp_o0 || busy[0] !== 1'b1 || done[0] !== 1'b0 ||
                out[1] !== exp_o1 || busy[1] !== exp_b1 || done[1] !== exp_d1) begin
                n_fail++;
                $display("[TB] FAIL indep k+%0d: out=%b busy=%b done=%b required out=%b%b busy=%b1 done=%b0",
                         j, out, busy, done, exp_o1, exp_o0, exp_b1, exp_d1);
            end
        end
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
    endtask

    task automatic test_full_scale();
        mode                        = 2'b00;
        half_period[0 +: CNT_W]     = CNT_W'(50_000_000);
        half_period[CNT_W +: CNT_W] = CNT_W'(50_000_000);
        start                       = 2'b11;
        tick();
        start = 2'b00;
        repeat (2000) tick();
        n_cmp++;
        if (out !== 2'b00 || busy !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL full_scale_run: out=%b busy=%b required 00/11", out, busy);
        end
        stop[1] = 1'b1;
        tick();
        stop[1]                     = 1'b0;
        half_period[CNT_W +: CNT_W] = CNT_W'(3);
        start[1]                    = 1'b1;
        tick();
        start[1] = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (out !== 2'b10 || busy !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL full_scale_mix: out=%b busy=%b required 10/11", out, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out !== 2'b00 || busy !== 2'b00 || done !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL async_reset: out=%b busy=%b done=%b required 00/00/00", out, busy, done);
        end
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (out !== 2'b00 || busy !== 2'b00 || done !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_no_done: out=%b busy=%b done=%b required 00/00/00", out, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_burst();
        test_edge_cases();
        test_independence();
        test_full_scale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
